// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_arb_pkg
// Description : Shared types and reset constants for the instruction-memory
//               arbiter: sequencer state, response owner, reset values and a
//               helper that selects the word returned to the requester.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

    // Sequencer state. IDLE is the only state in which a request can be taken.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Which requester the current transaction belongs to.
    typedef enum logic {
        FETCH = 1'b0,
        LOAD  = 1'b1
    } arb_owner_t;

    localparam arb_state_t  c_rst_state = IDLE;
    localparam arb_owner_t  c_rst_owner = FETCH;
    localparam logic [31:0] c_rst_data  = 32'd0;

    // Writes and rejected accesses carry no data back; only legal reads
    // return what the memory produced.
    function automatic logic [31:0] resp_word(input logic        is_read,
                                              input logic [31:0] rdata);
        return is_read ? rdata : 32'd0;
    endfunction

endpackage : imem_arb_pkg
`default_nettype wire

// File: rtl/imem_addr_check.sv
`default_nettype none
// ============================================================================
// Module      : imem_addr_check
// Description : Combinational legality check of a byte address against a
//               word memory of 2^DEPTH_LOG2 words. Produces the word index and
//               an error bit (misaligned or beyond the array).
// Ports       : i_addr  in  32          byte address
//               o_idx   out DEPTH_LOG2  word index (addr[DEPTH_LOG2+1:2])
//               o_err   out 1           address is not a legal word address
// Revision    : 1.0 - initial release
// ============================================================================
module imem_addr_check
    import imem_arb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic [31:0]           i_addr,
    output logic [DEPTH_LOG2-1:0] o_idx,
    output logic                  o_err
);

    logic w_misaligned;
    logic w_out_of_range;

    assign o_idx        = i_addr[DEPTH_LOG2+1:2];
    assign w_misaligned = |i_addr[1:0];

    // With a 2^30-word array every aligned address is in range, and the
    // upper-bit slice would be empty.
    generate
        if (DEPTH_LOG2 < 30) begin : g_range
            assign w_out_of_range = |i_addr[31:DEPTH_LOG2+2];
        end else begin : g_full_range
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign o_err = w_misaligned | w_out_of_range;

endmodule : imem_addr_check
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Single-port arbiter and access sequencer for the instruction
//               memory. The CPU fetch port (read-only) and the loader/debug
//               port (read/write) share one synchronous-read word memory.
//               Each accepted request runs IDLE -> ACCESS -> RESP, and the
//               response is held until its owner accepts it.
// Ports       : clk, rst_n                 clock, async active-low reset
//               f_req_valid/addr/ready     fetch request channel
//               f_rsp_valid/data/err/ready fetch response channel
//               l_req_valid/we/addr/wdata/ready  loader request channel
//               l_rsp_valid/data/err/ready loader response channel
//               mem_en/we/idx/wdata        memory strobe, write, index, data
//               mem_rdata                  memory read data (cycle after en)
// Build macro : IMEM_ARB_FAIRNESS_EN - when defined, fetch is granted after
//               FAIR_LIMIT consecutive loader grants taken while fetch waited.
//               When undefined the loader has strict priority.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int FAIR_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // fetch requester
    input  logic                  f_req_valid,
    input  logic [31:0]           f_req_addr,
    output logic                  f_req_ready,
    output logic                  f_rsp_valid,
    output logic [31:0]           f_rsp_data,
    output logic                  f_rsp_err,
    input  logic                  f_rsp_ready,
    // loader / debug requester
    input  logic                  l_req_valid,
    input  logic                  l_req_we,
    input  logic [31:0]           l_req_addr,
    input  logic [31:0]           l_req_wdata,
    output logic                  l_req_ready,
    output logic                  l_rsp_valid,
    output logic                  l_rsp_err,
    output logic [31:0]           l_rsp_data,
    input  logic                  l_rsp_ready,
    // memory array
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_idx,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    arb_owner_t r_owner;
    logic       r_we;          // transaction was a loader write
    logic       r_err;         // transaction address was illegal
    logic [31:0] r_rsp_data;

    logic        w_in_idle;
    logic        w_fair_turn;
    logic        w_grant_l;
    logic        w_grant_f;
    logic        w_accept;
    logic [31:0] w_sel_addr;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic        w_addr_err;
    logic        w_owner_rsp_ready;

    // ------------------------------------------------------------------
    // Fairness counter
    // ------------------------------------------------------------------
`ifdef IMEM_ARB_FAIRNESS_EN
    localparam int c_cnt_w = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_fair_max = c_cnt_w'(FAIR_LIMIT);

    logic [c_cnt_w-1:0] r_fair_cnt;

    assign w_fair_turn = (r_fair_cnt == c_fair_max);

    // Counts loader grants that made a waiting fetch lose. Once at the limit
    // the next contested grant goes to fetch and clears it; an uncontested
    // loader grant at the limit leaves it there, so it saturates naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fair_cnt <= '0;
        end else if (w_grant_f) begin
            r_fair_cnt <= '0;
        end else if (w_grant_l && f_req_valid && !w_fair_turn) begin
            r_fair_cnt <= r_fair_cnt + 1'b1;
        end
    end
`else
    logic w_unused_fair_limit;

    assign w_fair_turn         = 1'b0;
    assign w_unused_fair_limit = (FAIR_LIMIT < 0);
`endif

    // ------------------------------------------------------------------
    // Grant and address path
    // ------------------------------------------------------------------
    // Gated with rst_n so both readies fall the instant reset asserts, even
    // while requesters hold valid high.
    assign w_in_idle  = (r_state == IDLE) && rst_n;
    assign w_grant_l  = w_in_idle && l_req_valid && !(w_fair_turn && f_req_valid);
    assign w_grant_f  = w_in_idle && f_req_valid && !w_grant_l;
    assign w_accept   = w_grant_l || w_grant_f;
    assign w_sel_addr = w_grant_l ? l_req_addr : f_req_addr;

    imem_addr_check #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_addr_check (
        .i_addr (w_sel_addr),
        .o_idx  (w_idx),
        .o_err  (w_addr_err)
    );

    assign w_owner_rsp_ready = (r_owner == LOAD) ? l_rsp_ready : f_rsp_ready;

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_rst_state;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        f_req_ready  = 1'b0;
        l_req_ready  = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_idx      = '0;
        mem_wdata    = 32'd0;
        f_rsp_valid  = 1'b0;
        f_rsp_data   = 32'd0;
        f_rsp_err    = 1'b0;
        l_rsp_valid  = 1'b0;
        l_rsp_data   = 32'd0;
        l_rsp_err    = 1'b0;

        case (r_state)
            IDLE: begin
                f_req_ready = w_grant_f;
                l_req_ready = w_grant_l;
                // Illegal addresses never reach the array; the error is
                // latched and reported in the response instead.
                if (w_accept && !w_addr_err) begin
                    mem_en  = 1'b1;
                    mem_idx = w_idx;
                    if (w_grant_l && l_req_we) begin
                        mem_we    = 1'b1;
                        mem_wdata = l_req_wdata;
                    end
                end
                if (w_accept) begin
                    w_state_next = ACCESS;
                end
            end

            ACCESS: begin
                w_state_next = RESP;
            end

            RESP: begin
                if (r_owner == LOAD) begin
                    l_rsp_valid = 1'b1;
                    l_rsp_data  = r_rsp_data;
                    l_rsp_err   = r_err;
                end else begin
                    f_rsp_valid = 1'b1;
                    f_rsp_data  = r_rsp_data;
                    f_rsp_err   = r_err;
                end
                if (w_owner_rsp_ready) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction context and response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= c_rst_owner;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_rsp_data <= c_rst_data;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant_l ? LOAD : FETCH;
                r_we    <= w_grant_l && l_req_we;
                r_err   <= w_addr_err;
            end
            // Read data from the array is valid during ACCESS.
            if (r_state == ACCESS) begin
                r_rsp_data <= resp_word(!r_we && !r_err, mem_rdata);
            end
        end
    end

endmodule : imem_arbiter
`default_nettype wire
